multicycle_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/multicycle_alu_if.sv | 26 ++
 rtl/seq_muldiv_unit.sv | 76 +++++++
 rtl/multicycle_alu.sv | 118 +++++++++++
 tb/tb_multicycle_alu.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIVU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response handshake bundle between decode/control and writeback.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_code;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, alu_code, a, b, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, zero, div_by_zero
  );

  modport slave (
    input  in_valid, alu_code, a, b, out_ready,
    output in_ready, out_valid, result_lo, result_hi, zero, div_by_zero
  );
endinterface

// File: rtl/seq_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  localparam int CW = ($clog2(WIDTH) > 5) ? $clog2(WIDTH) : 5;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic             div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // res_* are the post-step values, so on the final step the owner can capture
  // them on the same edge that retires the operation.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    res_hi    = mul_sum[WIDTH:1];
    res_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        res_hi = div_diff[WIDTH-1:0];
        res_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        res_hi = div_shift[WIDTH-1:0];
        res_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      div_q  <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      div_q  <= op_div;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= a;
      opnd_q <= b;
    end else if (busy) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle ops plus iterative mul/divu behind valid/ready.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  multicycle_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state;
  logic             accept;
  logic             b_is_zero;
  logic             mdu_start;
  logic             mdu_done;
  logic [WIDTH-1:0] mdu_lo;
  logic [WIDTH-1:0] mdu_hi;
  logic [WIDTH-1:0] sc_result;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             dbz_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign b_is_zero = (bus.b == '0);
  assign shamt     = bus.a[SHW-1:0];
  assign mdu_start = accept && ((bus.alu_code == ALU_MUL) ||
                                ((bus.alu_code == ALU_DIVU) && !b_is_zero));

  assign bus.in_ready    = (state == ST_IDLE);
  assign bus.out_valid   = (state == ST_DONE);
  assign bus.result_lo   = lo_q;
  assign bus.result_hi   = hi_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

  always_comb begin
    sc_result = '0;
    case (bus.alu_code)
      ALU_ADD:  sc_result = bus.a + bus.b;
      ALU_SUB:  sc_result = bus.a - bus.b;
      ALU_AND:  sc_result = bus.a & bus.b;
      ALU_OR:   sc_result = bus.a | bus.b;
      ALU_NOR:  sc_result = ~(bus.a | bus.b);
      ALU_XOR:  sc_result = bus.a ^ bus.b;
      ALU_SRL:  sc_result = bus.b >> shamt;
      ALU_SLL:  sc_result = bus.b << shamt;
      ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default:  sc_result = '0;
    endcase
  end

  seq_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .op_div (bus.alu_code == ALU_DIVU),
    .a      (bus.a),
    .b      (bus.b),
    .done   (mdu_done),
    .res_lo (mdu_lo),
    .res_hi (mdu_hi)
  );

  // Single-cycle results are registered straight from the request, so the
  // operands never need their own holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      lo_q   <= '0;
      hi_q   <= '0;
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.alu_code == ALU_MUL) begin
              state <= ST_MUL;
            end else if (bus.alu_code == ALU_DIVU && !b_is_zero) begin
              state <= ST_DIV;
            end else if (bus.alu_code == ALU_DIVU) begin
              state  <= ST_DONE;
              lo_q   <= '1;
              hi_q   <= bus.a;
              zero_q <= 1'b0;
              dbz_q  <= 1'b1;
            end else begin
              state  <= ST_DONE;
              lo_q   <= sc_result;
              hi_q   <= '0;
              zero_q <= (sc_result == '0);
              dbz_q  <= 1'b0;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (mdu_done) begin
            state  <= ST_DONE;
            lo_q   <= mdu_lo;
            hi_q   <= mdu_hi;
            zero_q <= (mdu_lo == '0);
            dbz_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed-vector bench with a scoreboard queue drained by an independent monitor.
module tb_multicycle_alu;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(32)) bus ();

  multicycle_alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got lo=%h hi=%h with no request outstanding",
                 bus.result_lo, bus.result_hi);
      end else begin
        mon_e = sbq.pop_front();
        chk("result_lo", bus.result_lo, mon_e.lo);
        chk("result_hi", bus.result_hi, mon_e.hi);
        chk("zero", bus.zero, mon_e.z);
        chk("div_by_zero", bus.div_by_zero, mon_e.d);
      end
    end
  end

  task automatic send(input logic [3:0] code, input logic [31:0] va, input logic [31:0] vb,
                      input bit push, input logic [31:0] elo, input logic [31:0] ehi,
                      input logic ez, input logic ed);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.alu_code = code;
    bus.a        = va;
    bus.b        = vb;
    if (push) begin
      e.lo = elo; e.hi = ehi; e.z = ez; e.d = ed;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_code = ~code;
    bus.a        = ~va;
    bus.b        = vb ^ 32'h5A5A_0F0F;
  endtask

  task automatic wait_out(input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      chk("in_ready_busy", bus.in_ready, 0);
    end while (!bus.out_valid && lat < 100);
    chk("latency", lat, exp_lat);
  endtask

  task automatic run(input logic [3:0] code, input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] elo, input logic [31:0] ehi,
                     input logic ez, input logic ed, input int lat);
    send(code, va, vb, 1'b1, elo, ehi, ez, ed);
    wait_out(lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_code  = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result_lo", bus.result_lo, 0);
    chk("rst_result_hi", bus.result_hi, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run(ALU_ADD,  32'd7,         32'd5,         32'd12,        32'd0,         1'b0, 1'b0, 1);
    run(ALU_SUB,  32'd5,         32'd5,         32'd0,         32'd0,         1'b1, 1'b0, 1);
    run(ALU_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    run(ALU_DIVU, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 33);
    run(ALU_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9,         1'b0, 1'b1, 1);
    run(ALU_SLL,  32'd4,         32'd1,         32'd16,        32'd0,         1'b0, 1'b0, 1);
    run(ALU_SRL,  32'd36,        32'h8000_0000, 32'h0800_0000, 32'd0,         1'b0, 1'b0, 1);
    run(ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         32'd0,         1'b0, 1'b0, 1);
    run(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,         1'b1, 1'b0, 1);
    run(ALU_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0,         32'd0,         1'b1, 1'b0, 1);
    run(ALU_SLT,  32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd1,         32'd0,         1'b0, 1'b0, 1);
    run(ALU_AND,  32'hF0F0_1234, 32'hFF00_00FF, 32'hF000_0034, 32'd0,         1'b0, 1'b0, 1);
    run(ALU_OR,   32'hF0F0_0000, 32'h0F0F_0001, 32'hFFFF_0001, 32'd0,         1'b0, 1'b0, 1);
    run(ALU_NOR,  32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 1);
    run(ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 32'd0,         1'b0, 1'b0, 1);
    run(ALU_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 1);
    run(ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,         1'b1, 1'b0, 1);
    run(ALU_SLL,  32'd33,        32'd3,         32'd6,         32'd0,         1'b0, 1'b0, 1);
    run(4'b1111,  32'd1,         32'd2,         32'd0,         32'd0,         1'b1, 1'b0, 1);
    run(ALU_MUL,  32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1,         1'b1, 1'b0, 33);
    run(ALU_MUL,  32'd3,         32'd5,         32'd15,        32'd0,         1'b0, 1'b0, 33);
    run(ALU_DIVU, 32'd5,         32'd10,        32'd0,         32'd5,         1'b1, 1'b0, 33);
    run(ALU_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 33);

    // Backpressure: result held for five cycles while requests are offered.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(ALU_ADD, 32'd2, 32'd3, 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
    wait_out(1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (i % 2 == 0);
      bus.alu_code = ALU_ADD;
      bus.a        = 32'd100;
      bus.b        = 32'd100;
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_result_lo", bus.result_lo, 32'd5);
      chk("bp_result_hi", bus.result_hi, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", bus.out_valid, 1);
    @(negedge clk);
    chk("bp_in_ready_after", bus.in_ready, 1);
    chk("bp_out_valid_after", bus.out_valid, 0);
    @(negedge clk);
    chk("bp_no_phantom", bus.out_valid, 0);

    // Reset in the middle of a multiply abandons it.
    send(ALU_MUL, 32'h0000_1234, 32'h0000_5678, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_result_lo", bus.result_lo, 0);
    chk("midrst_result_hi", bus.result_hi, 0);
    chk("midrst_zero", bus.zero, 0);
    chk("midrst_dbz", bus.div_by_zero, 0);
    run(ALU_ADD, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1);

    repeat (40) @(negedge clk);
    chk("final_out_valid", bus.out_valid, 0);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
